// File: rtl/imm_enc.sv
// imm_enc: RISC-V immediate encoder; packs a 32-bit immediate into an I/S/B/J/U
// instruction, range/alignment checks it, and expands load-immediate into LUI+ADDI.
//
// Ports:
//   clk, resetn                  clock, asynchronous active-low reset
//   in_valid/in_ready            request handshake
//   in_inst, in_imm, in_sel      base instruction, immediate, format select
//                                (0 I, 1 S, 2 B, 3 J, 4 U, 5 LI, 6/7 reserved)
//   out_valid/out_ready          output beat handshake
//   out_inst, out_err, out_last  encoded beat, error flag, final-beat flag
//   err_count                    saturating count of requests flagged in error
//
// Build option: IMM_ENC_RANGE_CHECK_EN enables the I/S/B/J/U range and alignment
// checks; without it only reserved selects are flagged.
module imm_enc (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_imm,
    input  logic [2:0]  in_sel,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_err,
    output logic        out_last,
    output logic [7:0]  err_count
);
    typedef enum logic [1:0] {EMPTY, ONE, LI1} state_t;
    state_t      state;
    logic [31:0] addi_buf;
    logic [31:0] enc_inst;
    logic [31:0] addi_inst;
    logic [19:0] hi;
    logic [4:0]  rd;
    logic        fit12;
    logic        fit13;
    logic        fit21;
    logic        rng_err;
    logic        enc_err;
    logic        li2;
    logic        accept;

    // A value fits an N-bit signed field when all bits above N-1 equal the sign bit.
    assign fit12 = &in_imm[31:11] | ~|in_imm[31:11];
    assign fit13 = &in_imm[31:12] | ~|in_imm[31:12];
    assign fit21 = &in_imm[31:20] | ~|in_imm[31:20];
    assign rd    = in_inst[11:7];
    // Upper part rounded so the sign-extended ADDI low part lands on the target.
    assign hi    = in_imm[31:12] + {19'd0, in_imm[11]};
    assign li2   = (in_sel == 3'd5) && !fit12;

`ifdef IMM_ENC_RANGE_CHECK_EN
    assign rng_err = (in_sel == 3'd0 || in_sel == 3'd1) ? !fit12 :
                     (in_sel == 3'd2) ? (!fit13 || in_imm[0]) :
                     (in_sel == 3'd3) ? (!fit21 || in_imm[0]) :
                     (in_sel == 3'd4) ? |in_imm[11:0] : 1'b0;
`else
    assign rng_err = 1'b0;
`endif

    assign enc_err   = (in_sel[2] && in_sel[1]) || rng_err;
    assign addi_inst = {in_imm[11:0], rd, 3'b000, rd, 7'h13};
    assign enc_inst  =
        (in_sel == 3'd0) ? {in_imm[11:0], in_inst[19:0]} :
        (in_sel == 3'd1) ? {in_imm[11:5], in_inst[24:12], in_imm[4:0], in_inst[6:0]} :
        (in_sel == 3'd2) ? {in_imm[12], in_imm[10:5], in_inst[24:12], in_imm[4:1], in_imm[11], in_inst[6:0]} :
        (in_sel == 3'd3) ? {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_inst[11:0]} :
        (in_sel == 3'd4) ? {in_imm[31:12], in_inst[11:0]} :
        (in_sel == 3'd5) ? (fit12 ? {in_imm[11:0], 5'd0, 3'b000, rd, 7'h13} : {hi, rd, 7'h37}) :
        in_inst;

    assign out_valid = (state != EMPTY);
    assign in_ready  = resetn && ((state == EMPTY) || (state == ONE && out_ready));
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= EMPTY;
            out_inst  <= '0;
            out_err   <= 1'b0;
            out_last  <= 1'b0;
            addi_buf  <= '0;
            err_count <= '0;
        end else begin
            if (accept) begin
                out_inst <= enc_inst;
                out_err  <= enc_err;
                out_last <= !li2;
                addi_buf <= addi_inst;
                state    <= li2 ? LI1 : ONE;
            end else if (out_ready && state == LI1) begin
                out_inst <= addi_buf;
                out_err  <= 1'b0;
                out_last <= 1'b1;
                state    <= ONE;
            end else if (out_ready && state == ONE) begin
                state <= EMPTY;
            end
            if (accept && enc_err && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_imm_enc.sv
// tb_imm_enc: directed and randomized checks of imm_enc against a field-level model.
module tb_imm_enc;
    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_imm;
    logic [2:0]  in_sel;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_err;
    logic        out_last;
    logic [7:0]  err_count;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;
    logic [33:0] q[$];
    int bnd[15] = '{2047, 2048, -2048, -2049, 4094, 4095, 4096, -4096, -4098,
                    1048574, 1048576, -1048576, -1048578, 32'h12345000, 0};

    imm_enc dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_imm(in_imm), .in_sel(in_sel),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_err(out_err), .out_last(out_last),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected beats for one request, from the format rules in signed arithmetic.
    task automatic model(input logic [31:0] inst, input logic [31:0] imm, input logic [2:0] sel);
        int s;
        logic [31:0] r;
        logic [31:0] hi;
        logic e;
        s = $signed(imm);
        r = inst;
        e = 1'b0;
        if (sel == 3'd5) begin
            r = 32'h13;
            r[11:7] = inst[11:7];
            r[31:20] = imm[11:0];
            if (s >= -2048 && s <= 2047) q.push_back({r, 1'b0, 1'b1});
            else begin
                hi = (imm + 32'h800) >> 12;
                q.push_back({hi[19:0], inst[11:7], 7'h37, 1'b0, 1'b0});
                r[19:15] = inst[11:7];
                q.push_back({r, 1'b0, 1'b1});
            end
            return;
        end
        case (sel)
            3'd0: begin r[31:20] = imm[11:0]; e = s < -2048 || s > 2047; end
            3'd1: begin r[31:25] = imm[11:5]; r[11:7] = imm[4:0]; e = s < -2048 || s > 2047; end
            3'd2: begin
                r[31] = imm[12]; r[30:25] = imm[10:5]; r[11:8] = imm[4:1]; r[7] = imm[11];
                e = s < -4096 || s > 4094 || imm[0];
            end
            3'd3: begin
                r[31] = imm[20]; r[30:21] = imm[10:1]; r[20] = imm[11]; r[19:12] = imm[19:12];
                e = s < -1048576 || s > 1048574 || imm[0];
            end
            3'd4: begin r[31:12] = imm[31:12]; e = imm[11:0] != 12'd0; end
            default: e = 1'b1;
        endcase
`ifndef IMM_ENC_RANGE_CHECK_EN
        if (sel < 3'd5) e = 1'b0;
`endif
        q.push_back({r, e, 1'b1});
        if (e && exp_cnt < 255) exp_cnt++;
    endtask

    // One cycle, entered and left at the falling edge.
    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] imm,
                         input logic [2:0] sel, input logic ordy);
        logic acc;
        in_valid = v; in_inst = inst; in_imm = imm; in_sel = sel; out_ready = ordy;
        #1;
        check("out_valid", 32'(out_valid), 32'(q.size() != 0));
        check("in_ready", 32'(in_ready), 32'(q.size() == 0 || (q.size() == 1 && ordy)));
        if (q.size() != 0) begin
            check("out_inst", out_inst, q[0][33:2]);
            check("out_err", 32'(out_err), 32'(q[0][1]));
            check("out_last", 32'(out_last), 32'(q[0][0]));
            if (ordy) void'(q.pop_front());
        end
        acc = v && in_ready;
        if (acc) model(inst, imm, sel);
        @(posedge clk);
        @(negedge clk);
        check("err_count", 32'(err_count), 32'(exp_cnt));
    endtask

    task automatic idle(input logic ordy);
        drive(1'b0, 32'h0, 32'h0, 3'd0, ordy);
    endtask

    function automatic logic [31:0] pick_imm();
        int k;
        k = int'($urandom_range(0, 3));
        if (k == 0) return $urandom;
        if (k == 1) return 32'(int'($urandom_range(0, 8191)) - 4096);
        if (k == 2) return 32'(bnd[$urandom_range(0, 14)]);
        return 32'(int'($urandom_range(0, 4194303)) - 2097152);
    endfunction

    initial begin
        resetn = 1'b0; in_valid = 1'b0; in_inst = '0; in_imm = '0; in_sel = '0; out_ready = 1'b0;
        @(negedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_inst", out_inst, 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        // Directed examples
        drive(1'b1, 32'h00000013, 32'hFFFFF800, 3'd0, 1'b1);
        drive(1'b1, 32'h00000063, 32'h00001000, 3'd2, 1'b1);
        drive(1'b1, 32'h00000280, 32'h12345FFF, 3'd5, 1'b0);
        drive(1'b1, 32'h00000013, 32'h0, 3'd0, 1'b1);
        drive(1'b1, 32'h00000280, 32'hFFFFFFFF, 3'd5, 1'b1);
        drive(1'b1, 32'h00000063, 32'd4094, 3'd2, 1'b1);
        drive(1'b1, 32'h00000063, 32'hFFFFF000, 3'd2, 1'b1);
        drive(1'b1, 32'h0000006F, 32'd1048574, 3'd3, 1'b1);
        drive(1'b1, 32'h0000006F, 32'd1048575, 3'd3, 1'b1);
        drive(1'b1, 32'h00000023, 32'd2047, 3'd1, 1'b1);
        drive(1'b1, 32'h00000037, 32'h12345001, 3'd4, 1'b1);
        drive(1'b1, 32'hDEADBEEF, 32'h5, 3'd6, 1'b1);
        idle(1'b1);
        // Backpressure then back-to-back throughput
        drive(1'b1, 32'h00000013, 32'd100, 3'd0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h00000013, 32'd7, 3'd0, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, 32'h00000093, 32'(i * 3 + 1), 3'd0, 1'b1);
        idle(1'b1);
        // Saturation
        for (int i = 0; i < 300; i++) drive(1'b1, $urandom, $urandom, 3'd7, 1'b1);
        idle(1'b1);
        check("sat_err_count", 32'(err_count), 32'd255);
        // Asynchronous reset while the ADDI beat is buffered
        drive(1'b1, 32'h00000280, 32'h12345FFF, 3'd5, 1'b0);
        #2 resetn = 1'b0;
        #1;
        check("rst_li_valid", 32'(out_valid), 32'd0);
        check("rst_li_ready", 32'(in_ready), 32'd0);
        check("rst_li_count", 32'(err_count), 32'd0);
        q.delete();
        exp_cnt = 0;
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) idle(1'b1);
        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic [2:0] sel;
            sel = ($urandom_range(0, 9) == 0) ? 3'(6 + $urandom_range(0, 1)) : 3'($urandom_range(0, 5));
            drive(1'($urandom_range(0, 3) != 0), $urandom, pick_imm(), sel, 1'($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 4 && q.size() != 0; i++) idle(1'b1);
        check("drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/imm_enc.md
# imm_enc

Immediate encoder for the RISC-V toolchain-side datapath: the inverse of the core's immediate decoder. It takes a base instruction word, a 32-bit immediate and a format select, and re-packs the immediate into that format's scattered bit fields. It range- and alignment-checks the immediate, and expands load-immediate requests into a LUI/ADDI pair. It sits between the loader/relocation patcher and the instruction memory write port, with valid/ready handshakes on both sides.

## Interface
- No parameters.
- clk  input  1  clock, all state on rising edge
- resetn  input  1  asynchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  request accepted when in_valid && in_ready at clk edge
- in_inst  input  32  base instruction; non-immediate bits pass through
- in_imm  input  32  immediate value (two's complement)
- in_sel  input  3  000 I, 001 S, 010 B, 011 J, 100 U, 101 LI expand, 110/111 reserved
- out_valid  output  1  output beat valid
- out_ready  input  1  beat consumed when out_valid && out_ready
- out_inst  output  32  encoded instruction
- out_err  output  1  range/alignment/select error for this beat
- out_last  output  1  final beat of the request
- err_count  output  8  saturating count of requests flagged in error

## Operation
- Field packing; all bits not listed are copied from in_inst:
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
  - U: [31:12]=imm[31:12].
- Checks (signed):
  - I/S: imm in [-2048, 2047].
  - B: imm in [-4096, 4094] and imm[0]=0.
  - J: imm in [-1048576, 1048574] and imm[0]=0.
  - U: imm[11:0]=0.
  - On failure, the truncated encoding is still emitted, with out_err=1.
- LI (101): rd=in_inst[11:7]; in_inst's other bits are ignored.
  - If imm is in [-2048, 2047]: one beat, ADDI rd,x0,imm[11:0].
  - Otherwise two beats:
    - First beat: LUI rd,hi with hi=(imm+0x800)[31:12], mod 2^32.
    - Second beat: ADDI rd,rd,imm[11:0].
  - LI never errors.
- Reserved sel: out_inst=in_inst, out_err=1, single beat.
- err_count increments by 1 per accepted request with an error and saturates at 255.
- FSM states:
  - EMPTY: no beat held.
  - ONE: the final beat is held.
  - LI1: the LUI beat is held; the ADDI beat is buffered internally.
- Transitions:
  - EMPTY → ONE on accept of a single-beat request.
  - EMPTY → LI1 on accept of a two-beat LI.
  - ONE → EMPTY on consume with no new accept.
  - ONE → ONE or LI1 on simultaneous consume and accept.
  - LI1 → ONE on consume; out_inst becomes the ADDI beat.
- in_ready = (state==EMPTY) || (state==ONE && out_ready). It is 0 in LI1 and while resetn is low.

## Timing
- Latency 1: a request accepted at edge N is presented on out_* from edge N onward (visible cycle N+1).
- Throughput: 1 request/cycle for single-beat requests with out_ready held high. A two-beat LI occupies 2 output cycles.
- out_inst, out_err and out_last are held stable while out_valid && !out_ready.
- Simultaneous consume of the last beat and accept of a new request: the new beat replaces it at the same edge with no bubble.
- out_last is 0 only on the LUI beat. out_err is 0 on both LI beats.
- Reset state: out_valid=0, out_inst=0, out_err=0, out_last=0, err_count=0, state EMPTY.
- Reset mid-request: asserting resetn low discards any held or buffered beat, including a pending ADDI, immediately and asynchronously.

## Configuration
- IMM_ENC_RANGE_CHECK_EN:
  - Defined: the I/S/B/J/U range and alignment checks above are active.
  - Undefined: those checks are removed. out_err is raised only for reserved sel, and err_count counts only reserved-sel requests. Packing and LI behaviour are unchanged.

## Test plan
- I encode: in_inst=0x00000013, imm=0xFFFFF800, sel=000 → out_inst=0x80000013, err=0, last=1, one cycle after accept.
- B range: in_inst=0x00000063, imm=0x00001000, sel=010 → out_inst=0x80000063, err=1, err_count=1. With the macro undefined: err=0, err_count=0.
- LI pair: in_inst=0x00000280, imm=0x12345FFF, sel=101 → beat 0x123462B7 (last=0), then 0xFFF28293 (last=1); in_ready=0 between beats.
- LI short: in_inst=0x00000280, imm=0xFFFFFFFF, sel=101 → single beat 0xFFF00293, last=1.
- Backpressure/throughput: out_ready=0 for 3 cycles → out_* stable and in_ready=0. Then 4 back-to-back I requests with out_ready=1 → 4 beats on consecutive cycles, none lost. Then 300 reserved-sel requests → err_count saturates at 255.
- Reset mid-LI: resetn low while in LI1 → out_valid=0 immediately, no ADDI beat after release, err_count=0, in_ready=1 in the cycle after release.
